pipe_reg_chain: RTL

Parametrised chain of pipeline registers with per-stage stall and bubble control, valid tracking and hazard-misuse detection. It is the generalised successor to the single-field stage registers used between F/D/E/M/W. One instance can carry a whole stage bundle across STAGES consecutive stages. The hazard-control logic in the processor top drives `stall`/`bubble`; this block owns the register state and reports control errors.

---
 rtl/pipe_reg_chain.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
//
// Parametrised chain of STAGES pipeline registers carrying a WIDTH-bit payload
// plus a valid bit. Each stage can be held (stall) or squashed (bubble)
// independently by the hazard controller. The block does not propagate stalls
// itself. It only owns the register state and flags controller misuse:
//   ctrl_err  - stall and bubble asserted together on some stage
//   drop_err  - a valid entry was overwritten because its successor stalled
//   err_stage - lowest offending stage index of the first error cycle
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   When defined, per-stage saturating stall/bubble cycle counters are built.
//   When undefined, stall_cnt/bubble_cnt are tied to zero and no counter flops
//   exist.
//
// Parameters:
//   WIDTH      payload bits per stage
//   STAGES     number of register stages (1..8)
//   BUBBLE_VAL payload loaded on bubble or reset
//   CNT_W      width of each performance counter
//
// Ports:
//   clock      single clock, rising edge
//   reset      synchronous, active-high
//   in_data    payload entering stage 0
//   in_valid   in_data carries a real instruction
//   stall      bit i: stage i holds its contents
//   bubble     bit i: stage i loads BUBBLE_VAL with valid=0
//   out_data   stage i payload at bits [i*WIDTH +: WIDTH]
//   out_valid  bit i: stage i holds a real instruction
//   ctrl_err   sticky stall+bubble conflict flag
//   drop_err   sticky dropped-entry flag
//   err_stage  stage index of the first error, frozen once a flag is set
//   stall_cnt  per-stage stall cycle counts, CNT_W bits each
//   bubble_cnt per-stage bubble cycle counts, CNT_W bits each
// -----------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int               WIDTH      = 64,
  parameter int               STAGES     = 5,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         bubble,
  output logic [STAGES*WIDTH-1:0]   out_data,
  output logic [STAGES-1:0]         out_valid,
  output logic                      ctrl_err,
  output logic                      drop_err,
  output logic [2:0]                err_stage,
  output logic [STAGES*CNT_W-1:0]   stall_cnt,
  output logic [STAGES*CNT_W-1:0]   bubble_cnt
);

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic [STAGES-1:0][WIDTH-1:0] data_d;
  logic [STAGES-1:0][WIDTH-1:0] src_data;
  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0]            valid_d;
  logic [STAGES-1:0]            src_valid;

  // Per-stage error events, indexed by the stage that is blamed.
  logic [STAGES-1:0]            ctrl_hit;
  logic [STAGES-1:0]            drop_hit;
  logic [STAGES-1:0]            err_hit;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Stage 0 is fed from the input port, every other stage from its
      // predecessor's registered contents.
      if (gi == 0) begin : g_src_in
        assign src_data[gi]  = in_data;
        assign src_valid[gi] = in_valid;
      end else begin : g_src_prev
        assign src_data[gi]  = data_q[gi-1];
        assign src_valid[gi] = valid_q[gi-1];
      end

      assign ctrl_hit[gi] = stall[gi] & bubble[gi];

      // Stage gi loses its valid entry when its successor holds while gi
      // itself advances. A bubble on gi is a deliberate squash, not a loss.
      // The last stage is always consumed downstream, so it is never checked.
      if (gi < STAGES - 1) begin : g_drop
        assign drop_hit[gi] = stall[gi+1] & ~stall[gi] & valid_q[gi] & ~bubble[gi];
      end else begin : g_no_drop
        assign drop_hit[gi] = 1'b0;
      end

      assign out_data[gi*WIDTH +: WIDTH] = data_q[gi];
    end
  endgenerate

  assign err_hit   = ctrl_hit | drop_hit;
  assign out_valid = valid_q;

  // Stall beats bubble beats load. Reset is applied in the register process.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      if (!stall[i]) begin
        if (bubble[i]) begin
          data_d[i]  = BUBBLE_VAL;
          valid_d[i] = 1'b0;
        end else begin
          data_d[i]  = src_data[i];
          valid_d[i] = src_valid[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= BUBBLE_VAL;
      end
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error tracking
  // ---------------------------------------------------------------------------
  logic       ctrl_err_q, ctrl_err_d;
  logic       drop_err_q, drop_err_d;
  logic [2:0] err_stage_q, err_stage_d;
  logic [2:0] first_idx;

  // Scan from the top down so the lowest offending index is the one kept.
  always_comb begin
    first_idx = 3'd0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (err_hit[i]) begin
        first_idx = 3'(i);
      end
    end
  end

  always_comb begin
    ctrl_err_d  = ctrl_err_q | (|ctrl_hit);
    drop_err_d  = drop_err_q | (|drop_hit);
    err_stage_d = err_stage_q;
    // Only the first error cycle records a stage; later errors leave it alone.
    if (!(ctrl_err_q || drop_err_q) && (|err_hit)) begin
      err_stage_d = first_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_err_q  <= 1'b0;
      drop_err_q  <= 1'b0;
      err_stage_q <= 3'd0;
    end else begin
      ctrl_err_q  <= ctrl_err_d;
      drop_err_q  <= drop_err_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign ctrl_err  = ctrl_err_q;
  assign drop_err  = drop_err_q;
  assign err_stage = err_stage_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  logic [STAGES-1:0][CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAGES-1:0][CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters: once all-ones they stay there until reset.
  // A bubble that is overridden by a stall is not counted as a bubble.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    for (int i = 0; i < STAGES; i++) begin
      if (stall[i] && (stall_cnt_q[i] != {CNT_W{1'b1}})) begin
        stall_cnt_d[i] = stall_cnt_q[i] + CNT_W'(1);
      end
      if (bubble[i] && !stall[i] && (bubble_cnt_q[i] != {CNT_W{1'b1}})) begin
        bubble_cnt_d[i] = bubble_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_cnt_out
      assign stall_cnt[gi*CNT_W +: CNT_W]  = stall_cnt_q[gi];
      assign bubble_cnt[gi*CNT_W +: CNT_W] = bubble_cnt_q[gi];
    end
  endgenerate
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
